counter_top: RTL and testbench

- Free-running, prescaled up/down counter whose value drives a bank of LEDs.
- A prescaler divides the system clock by DIV. Each prescaler tick steps a WIDTH-bit counter up or down, as selected by dir.
- Counting is gated by enable.
- Top-level board block: clk and reset come from the board, enable and dir from switches, leds go to the board LEDs.

---
 rtl/counter_top.sv | 50 +++++
 tb/tb_counter_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_top.sv
`default_nettype none
// ============================================================================
// Module   : counter_top
// Brief    : Prescaled up/down counter driving a bank of board LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module counter_top #(
    parameter int WIDTH = 4,
    parameter int DIV   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] leds
);

    // DIV=1 still needs a 1-bit prescaler; it simply sits at its terminal value.
    localparam int            PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             tick;

    assign tick = enable && (prescale == PRE_LAST);

    // A disabled cycle keeps the partial period rather than restarting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
        end else if (enable) begin
            prescale <= tick ? '0 : prescale + PRE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= dir ? count + CNT_ONE : count - CNT_ONE;
        end
    end

    assign leds = count;

endmodule
`default_nettype wire

// File: tb/tb_counter_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_top
// Brief    : Directed self-checking bench for counter_top (DIV=5 and DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       dir;
    logic [3:0] leds;
    logic [3:0] leds1;

    int checks   = 0;
    int failures = 0;

    counter_top #(.WIDTH(4), .DIV(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dir    (dir),
        .leds   (leds)
    );

    counter_top #(.WIDTH(4), .DIV(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dir    (dir),
        .leds   (leds1)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so sampling is away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        dir    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (leds !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d leds=%0d expected=0", i, leds);
            end
            checks++;
            if (leds1 !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold_div1 cycle=%0d leds=%0d expected=0", i, leds1);
            end
        end
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (leds !== 4'd0) begin
                failures++;
                $display("FAIL idle_hold cycle=%0d leds=%0d expected=0", i, leds);
            end
        end
        enable = 1'b1;
        dir    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = 4'(k / 5);
            checks++;
            if (leds !== exp) begin
                failures++;
                $display("FAIL count_up edge=%0d leds=%0d expected=%0d", k, leds, exp);
            end
        end
    endtask

    task automatic test_dir_change();
        logic [3:0] exp;
        dir = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp = 4'(4 - (k / 5));
            checks++;
            if (leds !== exp) begin
                failures++;
                $display("FAIL count_down edge=%0d leds=%0d expected=%0d", k, leds, exp);
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        dir   = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            exp = 4'(k / 5);
            checks++;
            if (leds !== exp) begin
                failures++;
                $display("FAIL up_wrap edge=%0d leds=%0d expected=%0d", k, leds, exp);
            end
        end
    endtask

    task automatic test_enable_gating();
        // Three prescaler counts, then freeze for seven cycles.
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (leds !== 4'd0) begin
                failures++;
                $display("FAIL gate_hold cycle=%0d leds=%0d expected=0", i, leds);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (leds !== 4'd0) begin
            failures++;
            $display("FAIL gate_resume1 leds=%0d expected=0", leds);
        end
        step();
        checks++;
        if (leds !== 4'd1) begin
            failures++;
            $display("FAIL gate_resume2 leds=%0d expected=1", leds);
        end
        // Drop enable exactly on the would-be tick edge.
        for (int i = 0; i < 4; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (leds !== 4'd1) begin
                failures++;
                $display("FAIL tick_edge_hold cycle=%0d leds=%0d expected=1", i, leds);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (leds !== 4'd2) begin
            failures++;
            $display("FAIL tick_edge_resume leds=%0d expected=2", leds);
        end
    endtask

    task automatic test_reset_mid();
        // leds=2 with prescaler=0 here; climb to leds=9, prescaler=3.
        for (int i = 0; i < 38; i++) step();
        checks++;
        if (leds !== 4'd9) begin
            failures++;
            $display("FAIL mid_setup leds=%0d expected=9", leds);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (leds !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset leds=%0d expected=0", leds);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (leds !== ((k == 5) ? 4'd1 : 4'd0)) begin
                failures++;
                $display("FAIL mid_restart edge=%0d leds=%0d expected=%0d", k, leds, (k == 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_div1();
        logic [3:0] exp;
        reset  = 1'b1;
        enable = 1'b1;
        dir    = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = 4'(k);
            checks++;
            if (leds1 !== exp) begin
                failures++;
                $display("FAIL div1_up edge=%0d leds=%0d expected=%0d", k, leds1, exp);
            end
        end
        dir = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = 4'(20 - k);
            checks++;
            if (leds1 !== exp) begin
                failures++;
                $display("FAIL div1_down edge=%0d leds=%0d expected=%0d", k, leds1, exp);
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (leds1 !== 4'd14) begin
                failures++;
                $display("FAIL div1_hold cycle=%0d leds=%0d expected=14", k, leds1);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        dir    = 1'b1;
        test_reset();
        test_count_up();
        test_dir_change();
        test_up_wrap();
        test_enable_gating();
        test_reset_mid();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
